// File: rtl/irq_pending_ctrl.sv
// Sticky, maskable interrupt pending flags. The masked vector feeds a 4-input priority
// encoder, and one registered winner at a time is presented over a valid/ack handshake.
module irq_pending_ctrl #(
   parameter int unsigned EDGE_MODE  = 1,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [3:0] req_in,
   input  logic [3:0] mask_in,
   input  logic       ack_in,
   input  logic       clr_ovf_in,
   output logic [3:0] pend_masked_out,
   output logic [3:0] pending_out,
   output logic       irq_valid_out,
   output logic [1:0] irq_id_out,
   output logic       overflow_out
);

   typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

   // Last count value of the gap; unused when GAP_CYCLES is 0 because StGap is never entered.
   localparam logic [1:0] GapLast = (GAP_CYCLES == 0) ? 2'd0 : 2'(GAP_CYCLES - 1);

   state_e     r_state;
   logic [3:0] r_req_q;
   logic [3:0] r_pending;
   logic       r_valid;
   logic [1:0] r_id;
   logic       r_ovf;
   logic [1:0] r_gap_cnt;

   logic [3:0] w_set;
   logic [3:0] w_clr;
   logic [3:0] w_masked;
   logic [3:0] w_pending_d;
   logic       w_ack;
   logic       w_ovf_hit;
   logic [1:0] w_win_id;

   always_comb begin
      w_set = (EDGE_MODE != 0) ? (req_in & ~r_req_q) : req_in;
      w_ack = ack_in & r_valid;
      w_clr = 4'b0000;
      if (w_ack) begin
         w_clr[r_id] = 1'b1;
      end
      // Set beats clear on the same bit, so a fresh request during its own ack is kept.
      w_pending_d = (r_pending & ~w_clr) | w_set;
      w_ovf_hit   = (EDGE_MODE != 0) && ((w_set & r_pending & ~w_clr) != 4'b0000);
      w_masked    = r_pending & ~mask_in;
   end

   always_comb begin
      w_win_id = 2'd0;
      if (w_masked[3]) begin
         w_win_id = 2'd3;
      end else if (w_masked[2]) begin
         w_win_id = 2'd2;
      end else if (w_masked[1]) begin
         w_win_id = 2'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      // Loaded even in reset so a line already held high does not look like a new edge.
      r_req_q <= req_in;
      if (rst_in) begin
         r_pending <= 4'b0000;
         r_valid   <= 1'b0;
         r_id      <= 2'd0;
         r_ovf     <= 1'b0;
         r_gap_cnt <= 2'd0;
         r_state   <= StIdle;
      end else begin
         r_pending <= w_pending_d;
         if (w_ovf_hit) begin
            r_ovf <= 1'b1;
         end else if (clr_ovf_in) begin
            r_ovf <= 1'b0;
         end
         case (r_state)
            StIdle: begin
               if (w_masked != 4'b0000) begin
                  r_id    <= w_win_id;
                  r_valid <= 1'b1;
                  r_state <= StPresent;
               end
            end
            StPresent: begin
               if (w_ack) begin
                  r_valid   <= 1'b0;
                  r_gap_cnt <= 2'd0;
                  r_state   <= (GAP_CYCLES == 0) ? StIdle : StGap;
               end
            end
            StGap: begin
               if (r_gap_cnt == GapLast) begin
                  r_state <= StIdle;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 2'd1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign pend_masked_out = w_masked;
   assign pending_out     = r_pending;
   assign irq_valid_out   = r_valid;
   assign irq_id_out      = r_id;
   assign overflow_out    = r_ovf;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios on an edge/gap-1 instance and a level/gap-0
// instance, then random stimulus on both checked against a cycle-level reference model.
module tb_irq_pending_ctrl;

   localparam int unsigned A_EDGE = 1;
   localparam int unsigned A_GAP  = 1;
   localparam int unsigned B_EDGE = 0;
   localparam int unsigned B_GAP  = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a_req, a_mask, a_pm, a_pend;
   logic       a_ack, a_clr, a_valid, a_ovf;
   logic [1:0] a_id;
   logic [3:0] b_req, b_mask, b_pm, b_pend;
   logic       b_ack, b_clr, b_valid, b_ovf;
   logic [1:0] b_id;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, index 0 = instance A, 1 = instance B.
   logic [3:0] m_pend[2];
   logic [3:0] m_reqq[2];
   bit         m_valid[2];
   bit         m_ovf[2];
   int         m_id[2];
   int         m_hold[2];

   always #5 clk = ~clk;

   irq_pending_ctrl #(.EDGE_MODE(A_EDGE), .GAP_CYCLES(A_GAP)) u_dut_a (
      .clk_in(clk), .rst_in(rst), .req_in(a_req), .mask_in(a_mask), .ack_in(a_ack),
      .clr_ovf_in(a_clr), .pend_masked_out(a_pm), .pending_out(a_pend),
      .irq_valid_out(a_valid), .irq_id_out(a_id), .overflow_out(a_ovf)
   );

   irq_pending_ctrl #(.EDGE_MODE(B_EDGE), .GAP_CYCLES(B_GAP)) u_dut_b (
      .clk_in(clk), .rst_in(rst), .req_in(b_req), .mask_in(b_mask), .ack_in(b_ack),
      .clr_ovf_in(b_clr), .pend_masked_out(b_pm), .pending_out(b_pend),
      .irq_valid_out(b_valid), .irq_id_out(b_id), .overflow_out(b_ovf)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (a_pend !== 4'b0000) begin n_bad++; $display("FAIL rst_pend got %b want 0000", a_pend); end
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", a_valid); end
      n_cmp++; if (a_id !== 2'd0) begin n_bad++; $display("FAIL rst_id got %0d want 0", a_id); end
      n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", a_ovf); end
      n_cmp++; if (b_pm !== 4'b0000) begin n_bad++; $display("FAIL rst_pm_b got %b want 0000", b_pm); end
   endtask

   task automatic test_single();
      a_req = 4'b0001;
      step();
      a_req = 4'b0000;
      n_cmp++; if (a_pend !== 4'b0001) begin n_bad++; $display("FAIL t1_pend got %b want 0001", a_pend); end
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL t1_early_valid got %b want 0", a_valid); end
      step();
      n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'd0) begin
         n_bad++; $display("FAIL t1_present got valid=%b id=%0d want valid=1 id=0", a_valid, a_id); end
      a_ack = 1'b1;
      step();
      a_ack = 1'b0;
      n_cmp++; if (a_pend !== 4'b0000 || a_valid !== 1'b0) begin
         n_bad++; $display("FAIL t1_ack got pend=%b valid=%b want 0000/0", a_pend, a_valid); end
      step();
      step();
   endtask

   task automatic test_priority_order();
      logic [3:0] exp_pm;
      int k;
      a_req = 4'b1111;
      step();
      a_req = 4'b0000;
      n_cmp++; if (a_pend !== 4'b1111) begin n_bad++; $display("FAIL t2_pend got %b want 1111", a_pend); end
      step();
      for (int n = 0; n < 4; n++) begin
         exp_pm = 4'b1111 >> n;
         n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'(3 - n) || a_pm !== exp_pm) begin
            n_bad++; $display("FAIL t2_present got valid=%b id=%0d pm=%b want 1/%0d/%b",
                              a_valid, a_id, a_pm, 3 - n, exp_pm); end
         a_ack = 1'b1;
         step();
         a_ack = 1'b0;
         exp_pm = 4'b1111 >> (n + 1);
         n_cmp++; if (a_pm !== exp_pm || a_valid !== 1'b0) begin
            n_bad++; $display("FAIL t2_after_ack got pm=%b valid=%b want %b/0", a_pm, a_valid, exp_pm); end
         if (n < 3) begin
            k = 0;
            while (a_valid !== 1'b1 && k < 10) begin step(); k++; end
            n_cmp++; if (k != A_GAP + 1) begin
               n_bad++; $display("FAIL t2_gap got %0d wait cycles want %0d", k, A_GAP + 1); end
         end
      end
      step();
      step();
   endtask

   task automatic test_mask();
      int k;
      a_mask = 4'b1000;
      a_req  = 4'b1010;
      step();
      a_req = 4'b0000;
      n_cmp++; if (a_pend !== 4'b1010 || a_pm !== 4'b0010) begin
         n_bad++; $display("FAIL t3_pend got pend=%b pm=%b want 1010/0010", a_pend, a_pm); end
      step();
      n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'd1) begin
         n_bad++; $display("FAIL t3_present got valid=%b id=%0d want 1/1", a_valid, a_id); end
      a_mask = 4'b0010;
      step();
      n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'd1 || a_pm !== 4'b1000) begin
         n_bad++; $display("FAIL t3_hold got valid=%b id=%0d pm=%b want 1/1/1000", a_valid, a_id, a_pm); end
      a_mask = 4'b0000;
      a_ack  = 1'b1;
      step();
      a_ack = 1'b0;
      n_cmp++; if (a_pend !== 4'b1000) begin n_bad++; $display("FAIL t3_clear got %b want 1000", a_pend); end
      k = 0;
      while (a_valid !== 1'b1 && k < 10) begin step(); k++; end
      n_cmp++; if (k != A_GAP + 1 || a_id !== 2'd3) begin
         n_bad++; $display("FAIL t3_unmask got wait=%0d id=%0d want %0d/3", k, a_id, A_GAP + 1); end
      a_ack = 1'b1;
      step();
      a_ack = 1'b0;
      step();
      step();
   endtask

   task automatic test_ack_idle();
      a_mask = 4'b1111;
      a_req  = 4'b0001;
      step();
      a_req = 4'b0000;
      a_ack = 1'b1;
      step();
      step();
      n_cmp++; if (a_pend !== 4'b0001 || a_valid !== 1'b0 || a_pm !== 4'b0000) begin
         n_bad++; $display("FAIL idle_ack got pend=%b valid=%b pm=%b want 0001/0/0000",
                           a_pend, a_valid, a_pm); end
      a_ack  = 1'b0;
      a_mask = 4'b0000;
      step();
      n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'd0) begin
         n_bad++; $display("FAIL idle_unmask got valid=%b id=%0d want 1/0", a_valid, a_id); end
      a_ack = 1'b1;
      step();
      a_ack = 1'b0;
      n_cmp++; if (a_pend !== 4'b0000) begin n_bad++; $display("FAIL idle_drain got %b want 0000", a_pend); end
      step();
      step();
   endtask

   task automatic test_overflow();
      int k;
      a_req = 4'b0100;
      step();
      a_req = 4'b0000;
      step();
      n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'd2) begin
         n_bad++; $display("FAIL t4_present got valid=%b id=%0d want 1/2", a_valid, a_id); end
      a_req = 4'b0100;
      step();
      a_req = 4'b0000;
      n_cmp++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL t4_ovf_set got %b want 1", a_ovf); end
      step();
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL t4_ovf_clr got %b want 0", a_ovf); end
      a_req = 4'b0100;
      a_ack = 1'b1;
      step();
      a_req = 4'b0000;
      a_ack = 1'b0;
      n_cmp++; if (a_pend !== 4'b0100 || a_ovf !== 1'b0 || a_valid !== 1'b0) begin
         n_bad++; $display("FAIL t4_set_on_ack got pend=%b ovf=%b valid=%b want 0100/0/0",
                           a_pend, a_ovf, a_valid); end
      k = 0;
      while (a_valid !== 1'b1 && k < 10) begin step(); k++; end
      n_cmp++; if (k != A_GAP + 1 || a_id !== 2'd2) begin
         n_bad++; $display("FAIL t4_represent got wait=%0d id=%0d want %0d/2", k, a_id, A_GAP + 1); end
      a_req = 4'b0100;
      a_clr = 1'b1;
      step();
      a_req = 4'b0000;
      a_clr = 1'b0;
      n_cmp++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL t4_ovf_wins got %b want 1", a_ovf); end
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      a_ack = 1'b1;
      step();
      a_ack = 1'b0;
      n_cmp++; if (a_pend !== 4'b0000 || a_ovf !== 1'b0) begin
         n_bad++; $display("FAIL t4_drain got pend=%b ovf=%b want 0000/0", a_pend, a_ovf); end
      step();
      step();
      step();
   endtask

   task automatic test_reset_mid();
      a_req = 4'b0100;
      step();
      step();
      a_req = 4'b0000;
      step();
      a_req = 4'b0100;
      step();
      n_cmp++; if (a_valid !== 1'b1 || a_id !== 2'd2 || a_ovf !== 1'b1) begin
         n_bad++; $display("FAIL t5_pre got valid=%b id=%0d ovf=%b want 1/2/1", a_valid, a_id, a_ovf); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (a_pend !== 4'b0000 || a_valid !== 1'b0 || a_id !== 2'd0 || a_ovf !== 1'b0
                   || a_pm !== 4'b0000) begin
         n_bad++; $display("FAIL t5_reset got pend=%b valid=%b id=%0d ovf=%b pm=%b want all 0",
                           a_pend, a_valid, a_id, a_ovf, a_pm); end
      for (int i = 0; i < 4; i++) step();
      n_cmp++; if (a_valid !== 1'b0 || a_pend !== 4'b0000) begin
         n_bad++; $display("FAIL t5_no_edge got valid=%b pend=%b want 0/0000", a_valid, a_pend); end
      a_req = 4'b0000;
      step();
   endtask

   task automatic test_level_mode();
      int k;
      b_req = 4'b0001;
      step();
      n_cmp++; if (b_pend !== 4'b0001) begin n_bad++; $display("FAIL t6_pend got %b want 0001", b_pend); end
      step();
      n_cmp++; if (b_valid !== 1'b1 || b_id !== 2'd0) begin
         n_bad++; $display("FAIL t6_present got valid=%b id=%0d want 1/0", b_valid, b_id); end
      for (int r = 0; r < 3; r++) begin
         b_ack = 1'b1;
         step();
         b_ack = 1'b0;
         n_cmp++; if (b_valid !== 1'b0 || b_pend !== 4'b0001) begin
            n_bad++; $display("FAIL t6_ack got valid=%b pend=%b want 0/0001", b_valid, b_pend); end
         k = 0;
         while (b_valid !== 1'b1 && k < 10) begin step(); k++; end
         n_cmp++; if (k != 1 || b_id !== 2'd0) begin
            n_bad++; $display("FAIL t6_gap got wait=%0d id=%0d want 1/0", k, b_id); end
      end
      b_req = 4'b0000;
      b_ack = 1'b1;
      step();
      b_ack = 1'b0;
      for (int i = 0; i < 3; i++) step();
      n_cmp++; if (b_valid !== 1'b0 || b_pend !== 4'b0000 || b_ovf !== 1'b0) begin
         n_bad++; $display("FAIL t6_drop got valid=%b pend=%b ovf=%b want 0/0000/0",
                           b_valid, b_pend, b_ovf); end
   endtask

   // One clock of the behavioural model: request capture, ack acceptance, cool-down, arbitration.
   task automatic model_step(input int d, input bit edge_m, input int gap, input bit r,
                             input logic [3:0] req, input logic [3:0] mask,
                             input bit ack, input bit clr);
      logic [3:0] newp, masked;
      bit acc, hit, s, c;
      if (r) begin
         m_pend[d] = 4'b0000; m_valid[d] = 1'b0; m_id[d] = 0; m_ovf[d] = 1'b0;
         m_hold[d] = 0; m_reqq[d] = req;
         return;
      end
      acc = ack && m_valid[d];
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s = edge_m ? (req[k] && !m_reqq[d][k]) : req[k];
         c = acc && (m_id[d] == k);
         if (edge_m && s && m_pend[d][k] && !c) hit = 1'b1;
         newp[k] = s || (m_pend[d][k] && !c);
      end
      masked = m_pend[d] & ~mask;
      if (m_valid[d]) begin
         if (acc) begin m_valid[d] = 1'b0; m_hold[d] = gap; end
      end else if (m_hold[d] > 0) begin
         m_hold[d]--;
      end else if (masked != 4'b0000) begin
         m_valid[d] = 1'b1;
         for (int k = 0; k < 4; k++) if (masked[k]) m_id[d] = k;
      end
      if (hit) m_ovf[d] = 1'b1;
      else if (clr) m_ovf[d] = 1'b0;
      m_pend[d] = newp;
      m_reqq[d] = req;
   endtask

   task automatic test_random();
      logic [3:0] o_pm, o_pend, o_mask;
      logic [1:0] o_id;
      logic       o_valid, o_ovf;
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst = (cyc == 0) || ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 9) < 3) a_req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 3) b_req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 1) a_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 1) b_mask = 4'($urandom_range(0, 15));
         a_ack = ($urandom_range(0, 9) < 4);
         b_ack = ($urandom_range(0, 9) < 4);
         a_clr = ($urandom_range(0, 9) < 1);
         b_clr = ($urandom_range(0, 9) < 1);
         @(posedge clk);
         model_step(0, A_EDGE != 0, int'(A_GAP), rst, a_req, a_mask, a_ack, a_clr);
         model_step(1, B_EDGE != 0, int'(B_GAP), rst, b_req, b_mask, b_ack, b_clr);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            o_pm    = (d == 0) ? a_pm : b_pm;
            o_pend  = (d == 0) ? a_pend : b_pend;
            o_mask  = (d == 0) ? a_mask : b_mask;
            o_valid = (d == 0) ? a_valid : b_valid;
            o_id    = (d == 0) ? a_id : b_id;
            o_ovf   = (d == 0) ? a_ovf : b_ovf;
            n_cmp++; if (o_pend !== m_pend[d]) begin n_bad++;
               $display("FAIL rnd_pend dut%0d cyc %0d got %b want %b", d, cyc, o_pend, m_pend[d]); end
            n_cmp++; if (o_pm !== (m_pend[d] & ~o_mask)) begin n_bad++;
               $display("FAIL rnd_pm dut%0d cyc %0d got %b want %b", d, cyc, o_pm, m_pend[d] & ~o_mask); end
            n_cmp++; if (o_valid !== m_valid[d]) begin n_bad++;
               $display("FAIL rnd_valid dut%0d cyc %0d got %b want %b", d, cyc, o_valid, m_valid[d]); end
            n_cmp++; if (o_id !== 2'(m_id[d])) begin n_bad++;
               $display("FAIL rnd_id dut%0d cyc %0d got %0d want %0d", d, cyc, o_id, m_id[d]); end
            n_cmp++; if (o_ovf !== m_ovf[d]) begin n_bad++;
               $display("FAIL rnd_ovf dut%0d cyc %0d got %b want %b", d, cyc, o_ovf, m_ovf[d]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_req = 4'b0000; a_mask = 4'b0000; a_ack = 1'b0; a_clr = 1'b0;
      b_req = 4'b0000; b_mask = 4'b0000; b_ack = 1'b0; b_clr = 1'b0;
      test_reset();
      test_single();
      test_priority_order();
      test_mask();
      test_ack_idle();
      test_overflow();
      test_reset_mid();
      test_level_mode();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
